// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;
    localparam int CNT_W   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/decoder_3_to_8.sv
// Index-to-one-hot decoder with enable; output is all zero when disabled.
module decoder_3_to_8
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0]   a,
    input  logic               en,
    output logic [NUM_REQ-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[a] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters with a registered one-hot grant,
// owner release, withdrawal and a hold-time limit.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    // Compare value is deliberately truncated to the counter width.
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

    arb_state_e         state_q,     state_d;
    logic [IDX_W-1:0]   ptr_q,       ptr_d;
    logic [NUM_REQ-1:0] gnt_q,       gnt_d;
    logic [IDX_W-1:0]   gnt_id_q,    gnt_id_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q,   timeout_d;
    logic [CNT_W-1:0]   hold_cnt_q,  hold_cnt_d;

    logic [NUM_REQ-1:0] req_rot;
    logic [IDX_W-1:0]   ffs_idx;
    logic [IDX_W-1:0]   win_idx;
    logic               rel_withdraw;
    logic               rel_limit;

    // Rotate so bit 0 is the highest-priority requester, then find first set.
    always_comb begin
        req_rot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_rot[k] = req[ptr_q + IDX_W'(k)];
        end
        ffs_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                ffs_idx = IDX_W'(k);
            end
        end
        win_idx = ptr_q + ffs_idx;
    end

    assign rel_withdraw = ~req[gnt_id_q];
    assign rel_limit    = (hold_cnt_q == HOLD_LIMIT);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = GRANT;
                    gnt_id_d    = win_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (done || rel_withdraw || rel_limit) begin
                    state_d     = IDLE;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_id_q + IDX_W'(1);
                    hold_cnt_d  = '0;
                    // A limit release is only a timeout when nothing else released.
                    timeout_d   = rel_limit && !done && !rel_withdraw;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    decoder_3_to_8 u_dec (
        .a  (gnt_id_d),
        .en (gnt_valid_d),
        .y  (gnt_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed scenarios plus random traffic against a
// behavioural round-robin model.
module tb_rr_arbiter_8;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    always #5 clk = ~clk;

    rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model: m_held counts cycles the current grant has been visible.
    bit m_busy;
    int m_id;
    int m_ptr;
    int m_held;
    bit m_to;
    bit m_new;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_id   = 0;
        m_ptr  = 0;
        m_held = 0;
        m_to   = 1'b0;
        m_new  = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic d);
        bit found;
        bit normal_rel;
        m_to  = 1'b0;
        m_new = 1'b0;
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!found && r[(m_ptr + k) % 8]) begin
                    found  = 1'b1;
                    m_id   = (m_ptr + k) % 8;
                end
            end
            if (found) begin
                m_busy = 1'b1;
                m_held = 1;
                m_new  = 1'b1;
            end
        end else begin
            normal_rel = d || !r[m_id];
            if (normal_rel || m_held == MH) begin
                m_busy = 1'b0;
                m_ptr  = (m_id + 1) % 8;
                m_to   = !normal_rel;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] exp_gnt;
        exp_gnt = m_busy ? (8'd1 << m_id) : 8'd0;
        chk({tag, ".gnt"},       32'(gnt),           32'(exp_gnt));
        chk({tag, ".gnt_id"},    32'(gnt_id),        32'(m_id));
        chk({tag, ".gnt_valid"}, 32'(gnt_valid),     32'(m_busy));
        chk({tag, ".timeout"},   32'(timeout),       32'(m_to));
        chk({tag, ".ptr"},       32'(dut.ptr_q),     32'(m_ptr));
    endtask

    task automatic cycle(input string tag, input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        check_outputs(tag);
    endtask

    // Called at posedge+1; asserts rst between edges and checks the async clear.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs(tag);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        req  = 8'h00;
        done = 1'b0;
    endtask

    int exp_ids[$];
    int grants;
    int cnt_valid;
    int cnt_to;
    logic [7:0] r;

    initial begin
        rst  = 1'b0;
        req  = 8'h00;
        done = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset");

        for (int i = 0; i < 10; i++) cycle("idle", 8'h00, 1'b0);

        // Two requesters at opposite ends, released after 3 cycles each.
        exp_ids = '{0, 7, 0};
        grants  = 0;
        for (int i = 0; i < 40 && grants < 3; i++) begin
            cycle("r81", 8'h81, m_busy && m_held == 3);
            if (m_new) begin
                grants++;
                chk("r81.seq", 32'(gnt_id), 32'(exp_ids.pop_front()));
            end
        end
        chk("r81.count", 32'(grants), 32'd3);

        // Fairness and wrap with all requesters active.
        do_reset("reset2");
        exp_ids = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        grants  = 0;
        for (int i = 0; i < 60 && grants < 9; i++) begin
            cycle("rff", 8'hFF, m_busy);
            if (m_new) begin
                grants++;
                chk("rff.seq", 32'(gnt_id), 32'(exp_ids.pop_front()));
            end
        end
        chk("rff.count", 32'(grants), 32'd9);

        // Timeout: single requester never releases.
        do_reset("reset3");
        cnt_valid = 0;
        cnt_to    = 0;
        for (int i = 0; i < 5; i++) begin
            cycle("tmo", 8'h04, 1'b0);
            if (gnt_valid === 1'b1) cnt_valid++;
            if (timeout === 1'b1) cnt_to++;
        end
        chk("tmo.len", 32'(cnt_valid), 32'(MH));
        chk("tmo.pulse", 32'(cnt_to), 32'd1);
        cycle("tmo.regrant", 8'h04, 1'b0);
        chk("tmo.regrant_gnt", 32'(gnt), 32'h04);

        // done coincides with the limit cycle.
        do_reset("reset4");
        cnt_to = 0;
        for (int i = 0; i < 7; i++) begin
            cycle("lim_done", 8'h04, m_busy && m_held == MH);
            if (timeout === 1'b1) cnt_to++;
        end
        chk("lim_done.no_to", 32'(cnt_to), 32'd0);

        // Withdrawal coincides with the limit cycle.
        do_reset("reset5");
        cnt_to = 0;
        for (int i = 0; i < 7; i++) begin
            cycle("lim_wd", (m_busy && m_held == MH) ? 8'h00 : 8'h04, 1'b0);
            if (timeout === 1'b1) cnt_to++;
        end
        chk("lim_wd.no_to", 32'(cnt_to), 32'd0);

        // Reset in the middle of a grant to id 5.
        do_reset("reset6");
        cycle("mid", 8'h20, 1'b0);
        cycle("mid", 8'h20, 1'b0);
        chk("mid.gnt_before", 32'(gnt), 32'h20);
        do_reset("mid_rst");
        cycle("after", 8'h21, 1'b0);
        chk("after.first_id", 32'(gnt_id), 32'd0);
        cycle("after", 8'h21, 1'b1);
        cycle("after", 8'h21, 1'b0);

        // Random traffic.
        do_reset("reset7");
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       r = 8'h00;
                1:       r = 8'($urandom) & 8'($urandom);
                default: r = 8'($urandom);
            endcase
            cycle("rand", r, $urandom_range(0, 4) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
